// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the polyphonic voice allocator: FSM encoding and
// default sizing also used by the top-level voice/mixer wiring.
package voice_allocator_pkg;

  localparam int VA_NUM_VOICES = 4;
  localparam int VA_NOTE_BITS  = 7;
  localparam int VA_AGE_BITS   = 4;

  typedef enum logic [1:0] {
    VA_IDLE   = 2'd0,
    VA_SCAN   = 2'd1,
    VA_COMMIT = 2'd2
  } va_state_t;

endpackage

// File: rtl/voice_age.sv
// Per-voice saturating age counter; an inactive voice is held at age 0.
module voice_age #(
  parameter int AGE_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic                active,
  output logic [AGE_BITS-1:0] age
);

  function automatic logic [AGE_BITS-1:0] sat_inc(input logic [AGE_BITS-1:0] a);
    return (a == {AGE_BITS{1'b1}}) ? a : a + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clr || !active) begin
      age <= '0;
    end else if (inc) begin
      age <= sat_inc(age);
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Assigns note-on/off events to voices, scanning one voice per cycle and
// stealing the oldest gated voice when none is free.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = VA_NUM_VOICES,
  parameter int NOTE_BITS  = VA_NOTE_BITS,
  parameter int AGE_BITS   = VA_AGE_BITS
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ev_valid,
  output logic                            ev_ready,
  input  logic                            ev_on,
  input  logic [NOTE_BITS-1:0]            ev_note,
  input  logic                            all_off,
  output logic [NUM_VOICES-1:0]           gate,
  output logic [NUM_VOICES*NOTE_BITS-1:0] notes,
  output logic                            stolen
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  va_state_t state, state_nx;

  logic                 on_q;
  logic [NOTE_BITS-1:0] note_q;
  logic [IDX_W-1:0]     idx;
  logic                 match_found, free_found, old_found;
  logic [IDX_W-1:0]     match_idx, free_idx, old_idx, tgt;
  logic [AGE_BITS-1:0]  old_age;
  logic [NOTE_BITS-1:0] note_r [NUM_VOICES];
  logic [AGE_BITS-1:0]  age    [NUM_VOICES];
  logic [NUM_VOICES-1:0] age_clr, age_inc;
  logic                 take, commit;

  assign ev_ready = (state == VA_IDLE) && !all_off;
  assign take     = ev_valid && ev_ready;
  assign commit   = (state == VA_COMMIT) && !all_off;

  always_ff @(posedge clk) begin
    if (rst) state <= VA_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      VA_IDLE:   if (take) state_nx = VA_SCAN;
      VA_SCAN:   if (idx == LAST_IDX) state_nx = VA_COMMIT;
      VA_COMMIT: state_nx = VA_IDLE;
      default:   state_nx = VA_IDLE;
    endcase
    if (all_off) state_nx = VA_IDLE;
  end

  // Scan stage: latch the event at the handshake, then inspect one voice per cycle
  always_ff @(posedge clk) begin
    if (take) begin
      on_q        <= ev_on;
      note_q      <= ev_note;
      idx         <= '0;
      match_found <= 1'b0;
      free_found  <= 1'b0;
      old_found   <= 1'b0;
      match_idx   <= '0;
      free_idx    <= '0;
      old_idx     <= '0;
      old_age     <= '0;
    end else if (state == VA_SCAN) begin
      idx <= idx + 1'b1;
      if (gate[idx] && (note_r[idx] == note_q) && !match_found) begin
        match_found <= 1'b1;
        match_idx   <= idx;
      end
      if (!gate[idx] && !free_found) begin
        free_found <= 1'b1;
        free_idx   <= idx;
      end
      // strict compare keeps the lowest index on equal ages
      if (gate[idx] && (!old_found || (age[idx] > old_age))) begin
        old_found <= 1'b1;
        old_idx   <= idx;
        old_age   <= age[idx];
      end
    end
  end

  always_comb begin
    if (match_found)     tgt = match_idx;
    else if (free_found) tgt = free_idx;
    else                 tgt = old_idx;
  end

  always_comb begin
    age_clr = '0;
    age_inc = '0;
    if (all_off) begin
      age_clr = '1;
    end else if (commit) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (on_q) begin
          if (IDX_W'(i) == tgt) age_clr[i] = 1'b1;
          else                  age_inc[i] = 1'b1;
        end else if (match_found && (IDX_W'(i) == match_idx)) begin
          age_clr[i] = 1'b1;
        end
      end
    end
  end

  // Commit stage: gate/note/stolen registers only move here, on panic or reset
  always_ff @(posedge clk) begin
    if (rst) begin
      gate   <= '0;
      stolen <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) note_r[i] <= '0;
    end else begin
      stolen <= 1'b0;
      if (all_off) begin
        gate <= '0;
      end else if (commit) begin
        if (on_q) begin
          if (!match_found) begin
            note_r[tgt] <= note_q;
            gate[tgt]   <= 1'b1;
            stolen      <= !free_found;
          end
        end else if (match_found) begin
          gate[match_idx] <= 1'b0;
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_age #(.AGE_BITS(AGE_BITS)) u_age (
      .clk    (clk),
      .rst    (rst),
      .clr    (age_clr[i]),
      .inc    (age_inc[i]),
      .active (gate[i]),
      .age    (age[i])
    );
    assign notes[i*NOTE_BITS +: NOTE_BITS] = note_r[i];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: directed scenarios plus random
// events checked against an array-based behavioural model.
module tb_voice_allocator;

  localparam int NV = 4;
  localparam int NB = 7;
  localparam int AB = 4;
  localparam int AGE_MAX = (1 << AB) - 1;

  logic clk = 1'b0;
  logic rst, ev_valid, ev_on, all_off;
  logic [NB-1:0] ev_note;
  logic ev_ready, stolen;
  logic [NV-1:0] gate;
  logic [NV*NB-1:0] notes;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  bit mgate [NV];
  int mnote [NV];
  int mage  [NV];

  voice_allocator #(.NUM_VOICES(NV), .NOTE_BITS(NB), .AGE_BITS(AB)) dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .all_off(all_off),
    .gate(gate), .notes(notes), .stolen(stolen)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_gate();
    logic [31:0] g = '0;
    for (int i = 0; i < NV; i++) g[i] = mgate[i];
    return g;
  endfunction

  function automatic logic [31:0] exp_notes();
    logic [31:0] v = '0;
    for (int i = 0; i < NV; i++) v = v | (32'(mnote[i] & 8'h7f) << (i * NB));
    return v;
  endfunction

  function automatic void model_clear(input bit with_notes);
    for (int i = 0; i < NV; i++) begin
      mgate[i] = 1'b0;
      mage[i]  = 0;
      if (with_notes) mnote[i] = 0;
    end
  endfunction

  // Reference: choose a voice by the allocation rules, then age everybody else.
  function automatic void model_event(input bit on, input int n, output bit st);
    int m = -1, f = -1, o = -1, t;
    st = 1'b0;
    for (int i = 0; i < NV; i++) begin
      if (mgate[i] && mnote[i] == n && m < 0) m = i;
      if (!mgate[i] && f < 0) f = i;
      if (mgate[i] && (o < 0 || mage[i] > mage[o])) o = i;
    end
    if (on) begin
      if (m >= 0) t = m;
      else if (f >= 0) t = f;
      else begin t = o; st = 1'b1; end
      for (int i = 0; i < NV; i++)
        if (i != t && mgate[i] && mage[i] < AGE_MAX) mage[i]++;
      mnote[t] = n;
      mgate[t] = 1'b1;
      mage[t]  = 0;
    end else if (m >= 0) begin
      mgate[m] = 1'b0;
      mage[m]  = 0;
    end
  endfunction

  task automatic compare_state();
    check("gate", 32'(gate), exp_gate());
    check("notes", 32'(notes), exp_notes());
  endtask

  // Called at a negedge; returns at the negedge after commit.
  task automatic send_event(input bit on, input int n);
    int w = 0, low = 0, mid_st = 0;
    bit est;
    while (!ev_ready && w < 50) begin @(negedge clk); w++; end
    check("ready_wait", 32'(w < 50), 32'd1);
    ev_valid = 1'b1; ev_on = on; ev_note = NB'(n);
    @(negedge clk);
    ev_valid = 1'b0;
    ev_note = NB'($urandom);
    while (!ev_ready && low < 50) begin
      if (stolen) mid_st++;
      low++;
      @(negedge clk);
    end
    model_event(on, n, est);
    check("ready_low", 32'(low), 32'(NV + 1));
    check("stolen_early", 32'(mid_st), 32'd0);
    check("stolen", 32'(stolen), 32'(est));
    compare_state();
    @(negedge clk);
    check("stolen_pulse", 32'(stolen), 32'd0);
  endtask

  initial begin
    bit est;
    int t_acc [6];
    int w;
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; all_off = 1'b0;
    model_clear(1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_gate", 32'(gate), 32'd0);
    check("rst_notes", 32'(notes), 32'd0);
    check("rst_stolen", 32'(stolen), 32'd0);
    check("rst_ready", 32'(ev_ready), 32'd1);

    send_event(1, 60); send_event(1, 64); send_event(1, 67); send_event(1, 65);
    check("fill_gate", 32'(gate), 32'hf);
    check("fill_notes", 32'(notes), {4'd0, 7'd65, 7'd67, 7'd64, 7'd60});

    send_event(1, 72);
    check("steal_v0", 32'(notes[6:0]), 32'd72);
    check("steal_gate", 32'(gate), 32'hf);

    send_event(0, 64);
    check("off_gate", 32'(gate), 32'b1101);
    check("off_note_kept", 32'(notes[13:7]), 32'd64);
    send_event(1, 48);
    check("refill_v1", 32'(notes[13:7]), 32'd48);

    send_event(1, 72);
    check("dup_gate", 32'(gate), 32'hf);
    send_event(0, 70);
    check("off_nomatch", 32'(gate), 32'hf);
    send_event(1, 50);
    check("steal_oldest_v2", 32'(notes[20:14]), 32'd50);

    // panic during SCAN
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd33;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    all_off = 1'b1;
    #1 check("ready_in_alloff", 32'(ev_ready), 32'd0);
    @(negedge clk);
    check("alloff_gate", 32'(gate), 32'd0);
    all_off = 1'b0;
    #1 check("ready_after_alloff", 32'(ev_ready), 32'd1);
    model_clear(1'b0);
    repeat (NV + 2) @(negedge clk);
    compare_state();

    // reset while in COMMIT
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd44;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (NV) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstc_gate", 32'(gate), 32'd0);
    check("rstc_notes", 32'(notes), 32'd0);
    check("rstc_stolen", 32'(stolen), 32'd0);
    check("rstc_ready", 32'(ev_ready), 32'd1);
    rst = 1'b0;
    model_clear(1'b1);
    @(negedge clk);
    compare_state();

    // back-to-back stream with valid held high
    ev_valid = 1'b1; ev_on = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ev_note = NB'(20 + 3 * k);
      w = 0;
      while (!ev_ready && w < 50) begin @(negedge clk); w++; end
      check("b2b_wait", 32'(w < 50), 32'd1);
      t_acc[k] = cyc;
      model_event(1, 20 + 3 * k, est);
      @(negedge clk);
    end
    ev_valid = 1'b0;
    for (int k = 1; k < 6; k++) check("b2b_spacing", 32'(t_acc[k] - t_acc[k-1]), 32'(NV + 2));
    w = 0;
    while (!ev_ready && w < 50) begin @(negedge clk); w++; end
    compare_state();

    // randomized traffic with occasional panics
    for (int r = 0; r < 120; r++) begin
      if ($urandom_range(0, 29) == 0) begin
        all_off = 1'b1;
        #1 check("rnd_alloff_ready", 32'(ev_ready), 32'd0);
        @(negedge clk);
        all_off = 1'b0;
        model_clear(1'b0);
        compare_state();
      end else begin
        send_event($urandom_range(0, 2) != 0, 40 + $urandom_range(0, 5));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
